uart_rx_axis: RTL and testbench

//  Parametrised UART receiver with AXI-Stream master output and built-in elastic buffer.

---
 rtl/uart_rx_axis.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - UART receiver with AXI-Stream master output and elastic buffer (optional parity: UART_RX_PARITY_EN)
module uart_rx_axis #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rxd,
  input  logic                          i_m_axis_tready,
  output logic                          o_m_axis_tvalid,
  output logic [DATA_BITS-1:0]          o_m_axis_tdata,
  output logic [1:0]                    o_m_axis_tuser,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_lvl,
  output logic                          o_overflow,
  output logic                          o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic                 rxd_meta_q, rxs_q, rxs_prev_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 wr_q, wr_d;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        lvl_q, lvl_d, mem_cnt;
  logic                 out_valid_q, out_valid_d;
  logic [EW-1:0]        out_data_q, out_data_d;
  logic                 ovf_q, ovf_d;
  logic                 rd_fire, accept, mem_we, mem_empty;
  logic [EW-1:0]        wdata;

  // 2-FF synchroniser plus a delayed copy for start-edge detection; idles high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxs_q      <= rxd_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receiver state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      wr_q    <= wr_d;
    end
  end

  // Frame sequencing: mid-bit sampling, shift-in LSB first, error capture, write strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          perr_d  = ((^sh_q) ^ rxs_q) != 1'(PARITY_ODD);
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (!rxs_q) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            wr_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign wdata = {perr_q, ferr_q, sh_q};
`else
  assign wdata = {1'b0, ferr_q, sh_q};
`endif

  assign rd_fire   = out_valid_q & i_m_axis_tready;
  assign accept    = wr_q & ((lvl_q != FULL_LVL) | rd_fire);
  assign mem_cnt   = lvl_q - LW'(out_valid_q);
  assign mem_empty = (mem_cnt == '0);

  // Buffer control: output register is refilled from memory, or bypassed when memory is empty
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_we      = 1'b0;
    lvl_d       = lvl_q + LW'(accept) - LW'(rd_fire);
    ovf_d       = wr_q & ~accept;
    if (!out_valid_q || rd_fire) begin
      if (!mem_empty) begin
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
        mem_we      = accept;
      end else if (accept) begin
        out_data_d  = wdata;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      mem_we = accept;
    end
    if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
  end

  // Buffer pointers, level and output stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      lvl_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      lvl_q       <= lvl_d;
      ovf_q       <= ovf_d;
    end
  end

  // Buffer storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata;
  end

  assign o_m_axis_tvalid = out_valid_q;
  assign o_m_axis_tdata  = out_data_q[DATA_BITS-1:0];
  assign o_m_axis_tuser  = out_data_q[EW-1:DATA_BITS];
  assign o_fifo_lvl      = lvl_q;
  assign o_overflow      = ovf_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb/tb_uart_rx_axis.sv - directed self-checking bench for uart_rx_axis
module tb_uart_rx_axis;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int FD  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       tready = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic [1:0] tuser;
  logic [4:0] lvl;
  logic       ovf;
  logic       busy;

  uart_rx_axis #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(FD), .PARITY_ODD(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd), .i_m_axis_tready(tready),
    .o_m_axis_tvalid(tvalid), .o_m_axis_tdata(tdata), .o_m_axis_tuser(tuser),
    .o_fifo_lvl(lvl), .o_overflow(ovf), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       stop_v;
    logic [1:0] user_exp;
  } vec_t;

  vec_t       vecs [6];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  logic [9:0] rxq [$];
  int         rxc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture accepted transfers and overflow pulses just before the active edge
  always @(negedge clk) begin
    #2;
    if (rst_n && tvalid && tready) begin
      rxq.push_back({tuser, tdata});
      rxc.push_back(cyc);
    end
    if (rst_n && ovf) ovf_cnt = ovf_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    bit_time(1'b0);
    for (int i = 0; i < DB; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par_v);
`else
    if (par_v === 1'bx) rxd = 1'b1;
`endif
    for (int i = 0; i < SB; i++) bit_time(stop_v);
    idle(CPB / 2);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && rxq.size() < n; i++) @(negedge clk);
    check("rx_count", 32'(rxq.size()), 32'(n));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2'b00};
    vecs[1] = '{8'h3C, 1'b0, 2'b01};
    vecs[2] = '{8'h00, 1'b1, 2'b00};
    vecs[3] = '{8'hFF, 1'b1, 2'b00};
    vecs[4] = '{8'h5A, 1'b1, 2'b00};
    vecs[5] = '{8'h81, 1'b0, 2'b01};

    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tuser", 32'(tuser), 32'd0);
    check("rst_lvl", 32'(lvl), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(4);

    tready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      rxq.delete();
      send_frame(vecs[v].d, vecs[v].stop_v, ^vecs[v].d);
      wait_rx(1);
      if (rxq.size() > 0) begin
        check($sformatf("vec%0d_tdata", v), 32'(rxq[0][7:0]), 32'(vecs[v].d));
        check($sformatf("vec%0d_tuser", v), 32'(rxq[0][9:8]), 32'(vecs[v].user_exp));
      end
      idle(4);
      check($sformatf("vec%0d_lvl", v), 32'(lvl), 32'd0);
    end

    rxq.delete();
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    check("glitch_busy_on", 32'(busy), 32'd1);
    repeat (9) @(negedge clk);
    check("glitch_busy_off", 32'(busy), 32'd0);
    idle(2 * CPB);
    check("glitch_tvalid", 32'(tvalid), 32'd0);
    check("glitch_lvl", 32'(lvl), 32'd0);
    check("glitch_rx_count", 32'(rxq.size()), 32'd0);

    tready = 1'b0;
    rxq.delete();
    rxc.delete();
    ovf_cnt = 0;
    for (int b = 0; b <= FD; b++) send_frame(8'(b), 1'b1, ^(8'(b)));
    idle(CPB);
    check("full_lvl", 32'(lvl), 32'(FD));
    check("full_ovf_pulses", 32'(ovf_cnt), 32'd1);
    check("full_tvalid", 32'(tvalid), 32'd1);
    check("full_head_tdata", 32'(tdata), 32'd0);
    tready = 1'b1;
    wait_rx(FD);
    idle(4);
    for (int i = 0; i < FD && i < rxq.size(); i++)
      check($sformatf("drain%0d", i), 32'(rxq[i]), 32'(i));
    if (rxc.size() == FD) check("drain_b2b_cycles", 32'(rxc[FD-1] - rxc[0]), 32'(FD - 1));
    check("drain_lvl", 32'(lvl), 32'd0);
    check("drain_tvalid", 32'(tvalid), 32'd0);

    rxq.delete();
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tvalid", 32'(tvalid), 32'd0);
    check("mid_rst_lvl", 32'(lvl), 32'd0);
    check("mid_rst_tdata", 32'(tdata), 32'd0);
    rst_n = 1'b1;
    idle(CPB);
    send_frame(8'h5A, 1'b1, ^(8'h5A));
    wait_rx(1);
    if (rxq.size() > 0) check("post_rst_5a", 32'(rxq[0]), 32'h05A);
    idle(4);
    check("post_rst_lvl", 32'(lvl), 32'd0);

`ifdef UART_RX_PARITY_EN
    rxq.delete();
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_rx(2);
    if (rxq.size() > 1) begin
      check("par_bad", 32'(rxq[0]), 32'h207);
      check("par_good", 32'(rxq[1]), 32'h007);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
